master_bridge_sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for the master bridge. It buffers request/data words between the TL RX decode path and the AXI master channel logic, where both sides run on the same clock.
It generalises the bridge's dual-clock FIFO with the following additions:
- selectable first-word-fall-through (FWFT) or registered-read mode
- runtime almost-full and almost-empty thresholds
- fill-level output
- sticky overflow and underflow error flags

---
 rtl/master_bridge_sync_fifo_if.sv | 31 +++
 rtl/master_bridge_sync_fifo_mem.sv | 33 +++
 rtl/master_bridge_sync_fifo.sv | 113 +++++++++++
 tb/tb_master_bridge_sync_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/master_bridge_sync_fifo_if.sv
// ----------------------------------------------------------------------------
// master_bridge_sync_fifo_if
// Push/pop handshake and data bus between the TL RX decode path (producer),
// the AXI master channel logic (consumer) and the single-clock FIFO.
//   i_w_inc / i_w_data : push request and data (into the FIFO)
//   i_r_inc            : pop request (into the FIFO)
//   o_r_data           : head/read data (out of the FIFO)
//   o_w_full_flag      : FIFO full
//   o_r_empty_flag     : FIFO empty
// Modports: master = client driving push/pop, slave = the FIFO itself.
// ----------------------------------------------------------------------------
interface master_bridge_sync_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_w_inc;
    logic [DATA_WIDTH-1:0] i_w_data;
    logic                  i_r_inc;
    logic [DATA_WIDTH-1:0] o_r_data;
    logic                  o_w_full_flag;
    logic                  o_r_empty_flag;

    modport master (
        output i_w_inc, i_w_data, i_r_inc,
        input  o_r_data, o_w_full_flag, o_r_empty_flag
    );

    modport slave (
        input  i_w_inc, i_w_data, i_r_inc,
        output o_r_data, o_w_full_flag, o_r_empty_flag
    );
endinterface

// File: rtl/master_bridge_sync_fifo_mem.sv
// ----------------------------------------------------------------------------
// master_bridge_sync_fifo_mem
// 1-write / 1-read register array, 2**ADDR_WIDTH entries, no reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : asynchronous read address
//   o_rdata : read data (combinational from i_raddr)
// ----------------------------------------------------------------------------
module master_bridge_sync_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/master_bridge_sync_fifo.sv
// ----------------------------------------------------------------------------
// master_bridge_sync_fifo
// Single-clock FIFO between TL RX decode and the AXI master channel logic.
// FWFT=1 presents the head word combinationally; FWFT=0 registers the read
// data on each accepted pop.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   bus (slave)           : push/pop handshake, data, full/empty flags
//   i_af_thresh           : almost-full threshold  (level >= thresh)
//   i_ae_thresh           : almost-empty threshold (level <= thresh)
//   i_clr_err             : clears sticky error flags
//   o_w_almost_full_flag  : almost full
//   o_r_almost_empty_flag : almost empty
//   o_level               : occupancy 0..2**ADDR_WIDTH
//   o_overflow            : sticky, push attempted while full
//   o_underflow           : sticky, pop attempted while empty
// ----------------------------------------------------------------------------
module master_bridge_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int FWFT       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    master_bridge_sync_fifo_if.slave bus,
    input  logic [ADDR_WIDTH:0]   i_af_thresh,
    input  logic [ADDR_WIDTH:0]   i_ae_thresh,
    input  logic                  i_clr_err,
    output logic                  o_w_almost_full_flag,
    output logic                  o_r_almost_empty_flag,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_underflow
);
    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      w_level;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic                  r_overflow;
    logic                  r_underflow;

    // Flags decode only the registered pointers; the extra MSB tells a full
    // FIFO apart from an empty one when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_level = r_wr_ptr - r_rd_ptr;

    assign w_push = bus.i_w_inc && !w_full;
    assign w_pop  = bus.i_r_inc && !w_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Set has priority over clear so an error in the clearing cycle survives.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.i_w_inc && w_full)       r_overflow <= 1'b1;
            else if (i_clr_err)              r_overflow <= 1'b0;
            if (bus.i_r_inc && w_empty)      r_underflow <= 1'b1;
            else if (i_clr_err)              r_underflow <= 1'b0;
        end
    end

    master_bridge_sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (bus.i_w_data),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_mem_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Stale array contents are masked so an empty FIFO reads as zero.
            assign bus.o_r_data = w_empty ? '0 : w_mem_rdata;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rd_data;
            always_ff @(posedge i_clk) begin
                if (i_rst)      r_rd_data <= '0;
                else if (w_pop) r_rd_data <= w_mem_rdata;
            end
            assign bus.o_r_data = r_rd_data;
        end
    endgenerate

    assign bus.o_w_full_flag     = w_full;
    assign bus.o_r_empty_flag    = w_empty;
    assign o_level               = w_level;
    assign o_w_almost_full_flag  = (w_level >= i_af_thresh);
    assign o_r_almost_empty_flag = (w_level <= i_ae_thresh);
    assign o_overflow            = r_overflow;
    assign o_underflow           = r_underflow;
endmodule

// File: tb/tb_master_bridge_sync_fifo.sv
module tb_master_bridge_sync_fifo;
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic [AW:0]   af_th;
    logic [AW:0]   ae_th;
    logic          clr;

    logic          af_a, ae_a, ovf_a, unf_a;
    logic [AW:0]   lvl_a;
    logic          af_b, ae_b, ovf_b, unf_b;
    logic [AW:0]   lvl_b;

    master_bridge_sync_fifo_if #(.DATA_WIDTH(DW)) bus_a ();
    master_bridge_sync_fifo_if #(.DATA_WIDTH(DW)) bus_b ();

    master_bridge_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut_a (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .bus                   (bus_a),
        .i_af_thresh           (af_th),
        .i_ae_thresh           (ae_th),
        .i_clr_err             (clr),
        .o_w_almost_full_flag  (af_a),
        .o_r_almost_empty_flag (ae_a),
        .o_level               (lvl_a),
        .o_overflow            (ovf_a),
        .o_underflow           (unf_a)
    );

    master_bridge_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut_b (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .bus                   (bus_b),
        .i_af_thresh           (af_th),
        .i_ae_thresh           (ae_th),
        .i_clr_err             (clr),
        .o_w_almost_full_flag  (af_b),
        .o_r_almost_empty_flag (ae_b),
        .o_level               (lvl_b),
        .o_overflow            (ovf_b),
        .o_underflow           (unf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: contents as a queue, sticky flags, registered read word.
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;
    logic [DW-1:0] m_rdreg;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit w, input logic [DW-1:0] d, input bit r,
                              input bit c, input bit rs);
        bit full_now, empty_now;
        logic [DW-1:0] popped;
        if (rs) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_rdreg = '0;
        end else begin
            full_now  = (q.size() == DEPTH);
            empty_now = (q.size() == 0);
            m_ovf = (w && full_now)  ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_unf = (r && empty_now) ? 1'b1 : (c ? 1'b0 : m_unf);
            if (r && !empty_now) begin
                popped  = q.pop_front();
                m_rdreg = popped;
            end
            if (w && !full_now) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int            sz;
        logic [DW-1:0] head;
        sz   = q.size();
        head = (sz == 0) ? '0 : q[0];
        chk("a_level", DW'(lvl_a), DW'(sz));
        chk("a_full",  DW'(bus_a.o_w_full_flag),  DW'(sz == DEPTH));
        chk("a_empty", DW'(bus_a.o_r_empty_flag), DW'(sz == 0));
        chk("a_af",    DW'(af_a),  DW'(sz >= int'(af_th)));
        chk("a_ae",    DW'(ae_a),  DW'(sz <= int'(ae_th)));
        chk("a_ovf",   DW'(ovf_a), DW'(m_ovf));
        chk("a_unf",   DW'(unf_a), DW'(m_unf));
        chk("a_rdata", bus_a.o_r_data, head);
        chk("b_level", DW'(lvl_b), DW'(sz));
        chk("b_full",  DW'(bus_b.o_w_full_flag),  DW'(sz == DEPTH));
        chk("b_empty", DW'(bus_b.o_r_empty_flag), DW'(sz == 0));
        chk("b_af",    DW'(af_b),  DW'(sz >= int'(af_th)));
        chk("b_ae",    DW'(ae_b),  DW'(sz <= int'(ae_th)));
        chk("b_ovf",   DW'(ovf_b), DW'(m_ovf));
        chk("b_unf",   DW'(unf_b), DW'(m_unf));
        chk("b_rdata", bus_b.o_r_data, m_rdreg);
    endtask

    // One clock: drive both FIFOs identically, advance the model at the edge,
    // then compare everything on the falling edge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit c, input bit rs);
        bus_a.i_w_inc = w; bus_a.i_w_data = d; bus_a.i_r_inc = r;
        bus_b.i_w_inc = w; bus_b.i_w_data = d; bus_b.i_r_inc = r;
        clr = c;
        rst = rs;
        @(posedge clk);
        model_step(w, d, r, c, rs);
        @(negedge clk);
        bus_a.i_w_inc = 1'b0; bus_a.i_r_inc = 1'b0;
        bus_b.i_w_inc = 1'b0; bus_b.i_r_inc = 1'b0;
        clr = 1'b0;
        rst = 1'b0;
        check_all();
    endtask

    task automatic push(input logic [DW-1:0] d); cyc(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
    task automatic pop();                       cyc(1'b0, '0, 1'b1, 1'b0, 1'b0); endtask
    task automatic idle();                      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0); endtask
    task automatic reset_fifo();                cyc(1'b0, '0, 1'b0, 1'b0, 1'b1); endtask

    initial begin
        logic [DW-1:0] d;
        bit w, r, c, rs;
        bus_a.i_w_inc = 1'b0; bus_a.i_w_data = '0; bus_a.i_r_inc = 1'b0;
        bus_b.i_w_inc = 1'b0; bus_b.i_w_data = '0; bus_b.i_r_inc = 1'b0;
        rst = 1'b1; clr = 1'b0;
        af_th = 4'd6; ae_th = 4'd2;
        m_ovf = 1'b0; m_unf = 1'b0; m_rdreg = '0;

        @(negedge clk);
        reset_fifo();
        reset_fifo();
        chk("rst_level", DW'(lvl_a), '0);
        chk("rst_empty", DW'(bus_a.o_r_empty_flag), DW'(1));
        chk("rst_rdata_b", bus_b.o_r_data, '0);

        // Fill, threshold crossings, overflow.
        for (int i = 0; i < DEPTH; i++) begin
            push(DW'(32'hA0 + i));
            if (i == 4) chk("af_at5", DW'(af_a), DW'(0));
            if (i == 5) chk("af_at6", DW'(af_a), DW'(1));
            if (i == 1) chk("ae_at2", DW'(ae_a), DW'(1));
            if (i == 2) chk("ae_at3", DW'(ae_a), DW'(0));
        end
        chk("full_after_8", DW'(bus_a.o_w_full_flag), DW'(1));
        chk("level_8", DW'(lvl_a), DW'(8));
        push(32'hFF);
        chk("overflow_set", DW'(ovf_a), DW'(1));
        chk("level_stays_8", DW'(lvl_a), DW'(8));

        // Drain in order, then underflow and clear.
        for (int i = 0; i < DEPTH; i++) begin
            chk("fwft_seq", bus_a.o_r_data, DW'(32'hA0 + i));
            pop();
            chk("reg_seq", bus_b.o_r_data, DW'(32'hA0 + i));
        end
        chk("empty_after_drain", DW'(bus_a.o_r_empty_flag), DW'(1));
        chk("rdata_zero_empty", bus_a.o_r_data, '0);
        pop();
        chk("underflow_set", DW'(unf_a), DW'(1));
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("ovf_cleared", DW'(ovf_a), DW'(0));
        chk("unf_cleared", DW'(unf_a), DW'(0));

        // Simultaneous push/pop at level 4, then from empty.
        for (int i = 0; i < 4; i++) push(DW'(32'hB0 + i));
        cyc(1'b1, 32'hB4, 1'b1, 1'b0, 1'b0);
        chk("pp_level4", DW'(lvl_a), DW'(4));
        for (int i = 0; i < 4; i++) pop();
        cyc(1'b1, 32'hC5, 1'b1, 1'b0, 1'b0);
        chk("pp_empty_level", DW'(lvl_a), DW'(1));
        chk("pp_empty_unf", DW'(unf_a), DW'(1));
        chk("pp_empty_data", bus_a.o_r_data, 32'hC5);
        pop();
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Wrap-around with a partial prefill so both pointers cross the MSB.
        for (int i = 0; i < 5; i++) push(DW'(32'hD00 + i));
        for (int i = 0; i < 20; i++) begin
            push(DW'(32'hE00 + i));
            pop();
        end
        while (q.size() != 0) pop();

        // Threshold edges.
        for (int i = 0; i < DEPTH; i++) push(DW'(32'hF0 + i));
        af_th = 4'd9; ae_th = 4'd8;
        #1 chk("af_thresh9_full", DW'(af_a), DW'(0));
        chk("ae_thresh8_full", DW'(ae_a), DW'(1));
        af_th = 4'd0;
        #1 chk("af_thresh0", DW'(af_a), DW'(1));
        @(negedge clk);
        while (q.size() != 0) pop();
        af_th = 4'd6; ae_th = 4'd2;

        // Registered-read holding behaviour.
        reset_fifo();
        push(32'h11);
        push(32'h22);
        pop();
        chk("reg_first", bus_b.o_r_data, 32'h11);
        idle(); idle();
        chk("reg_hold", bus_b.o_r_data, 32'h11);
        pop();
        chk("reg_second", bus_b.o_r_data, 32'h22);
        idle();
        chk("reg_hold_empty", bus_b.o_r_data, 32'h22);

        // Reset mid-operation at level 5 with overflow set.
        for (int i = 0; i < DEPTH; i++) push(DW'(32'h300 + i));
        push(32'hDEAD);
        for (int i = 0; i < 3; i++) pop();
        chk("pre_rst_level5", DW'(lvl_b), DW'(5));
        reset_fifo();
        chk("post_rst_empty", DW'(bus_b.o_r_empty_flag), DW'(1));
        chk("post_rst_ovf", DW'(ovf_b), DW'(0));
        chk("post_rst_rdata", bus_b.o_r_data, '0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                af_th = AW'(0) + ($urandom_range(0, 15));
                ae_th = AW'(0) + ($urandom_range(0, 15));
            end
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 50);
            c  = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 99) == 0);
            d  = $urandom;
            cyc(w, d, r, c, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
